// File: rtl/span_pkg.sv
// Shared types and widths for the span scan-risk scheduler.
package span_pkg;

    localparam int unsigned POS_W       = 16;
    localparam int unsigned RISK_W      = 16;
    localparam int unsigned PSR_W       = 16;
    localparam int unsigned NUM_POS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/span_scan_sched_if.sv
// Bundles the requester, engine and result signals of the scan-risk scheduler.
interface span_scan_sched_if
    import span_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_POS = NUM_POS_DEF
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*PSR_W-1:0]         req_psr;
    logic [NUM_REQ*NUM_POS*POS_W-1:0] req_pos;
    logic                             eng_start;
    logic [PSR_W-1:0]                 eng_psr;
    logic [NUM_POS*POS_W-1:0]         eng_pos;
    logic [RISK_W-1:0]                eng_risk;
    logic                             res_valid;
    logic                             res_ready;
    logic [ID_W-1:0]                  res_id;
    logic [RISK_W-1:0]                res_risk;

    modport master (
        input  req_valid, req_psr, req_pos, eng_risk, res_ready,
        output req_ready, eng_start, eng_psr, eng_pos, res_valid, res_id, res_risk
    );

    modport slave (
        output req_valid, req_psr, req_pos, eng_risk, res_ready,
        input  req_ready, eng_start, eng_psr, eng_pos, res_valid, res_id, res_risk
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/span_scan_sched.sv
// Shares one scan-risk engine among NUM_REQ requesters, round-robin, one job at a time.
// Optional SPAN_SCHED_ZERO_BYPASS_EN: zero net-position portfolios skip the engine.
module span_scan_sched
    import span_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_POS    = NUM_POS_DEF,
    parameter int unsigned ENGINE_LAT = 1
) (
    input logic                clk,
    input logic                reset,
    span_scan_sched_if.master  bus
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (ENGINE_LAT > 1) ? $clog2(ENGINE_LAT) : 1;
    localparam int unsigned VEC_W = NUM_POS * POS_W;

    sched_state_t         state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      ptr_next;
    logic [NUM_REQ-1:0]   grant;
    logic [PSR_W-1:0]     sel_psr;
    logic [VEC_W-1:0]     sel_pos;
    logic [PSR_W-1:0]     hold_psr;
    logic [VEC_W-1:0]     hold_pos;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 eng_start_r;
    logic                 res_valid_r;
    logic [ID_W-1:0]      res_id_r;
    logic [RISK_W-1:0]    res_risk_r;
    logic                 bypass;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_psr  = bus.req_psr[int'(grant_idx)*PSR_W +: PSR_W];
    assign sel_pos  = bus.req_pos[int'(grant_idx)*VEC_W +: VEC_W];
    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef SPAN_SCHED_ZERO_BYPASS_EN
    logic [POS_W-1:0] pos_sum;

    // Wrapping sum, so offsetting positions of any size cancel exactly.
    always_comb begin
        pos_sum = '0;
        for (int unsigned j = 0; j < NUM_POS; j++) begin
            pos_sum = pos_sum + sel_pos[j*POS_W +: POS_W];
        end
    end

    assign bypass = (pos_sum == '0);
`else
    assign bypass = 1'b0;
`endif

    // Grants are offered only in IDLE and never while reset is held.
    assign bus.req_ready = (state == IDLE && reset) ? grant : '0;
    assign bus.eng_start = eng_start_r;
    assign bus.eng_psr   = hold_psr;
    assign bus.eng_pos   = hold_pos;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_risk  = res_risk_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold_psr    <= '0;
            hold_pos    <= '0;
            wait_cnt    <= '0;
            eng_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_risk_r  <= '0;
        end else begin
            eng_start_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        rr_ptr   <= ptr_next;
                        res_id_r <= grant_idx;
                        if (bypass) begin
                            res_risk_r  <= '0;
                            res_valid_r <= 1'b1;
                            state       <= RESP;
                        end else begin
                            hold_psr    <= sel_psr;
                            hold_pos    <= sel_pos;
                            eng_start_r <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(ENGINE_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        res_risk_r  <= bus.eng_risk;
                        res_valid_r <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_span_scan_sched.sv
// Directed bench for span_scan_sched: cycle model plus result scoreboard, latency-accurate engine.
module tb_span_scan_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NPOS = 8;
    localparam int unsigned LAT  = 2;

    typedef struct {
        int          id;
        logic [15:0] psr;
        logic [127:0] pos;
        logic [15:0] risk;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    span_scan_sched_if #(.NUM_REQ(NREQ), .NUM_POS(NPOS)) bus ();

    span_scan_sched #(
        .NUM_REQ    (NREQ),
        .NUM_POS    (NPOS),
        .ENGINE_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0]  psr_a [NREQ];
    logic [127:0] pos_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign bus.req_psr[i*16 +: 16]   = psr_a[i];
        assign bus.req_pos[i*128 +: 128] = pos_a[i];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] sum_of(input logic [127:0] pos);
        logic [15:0] s;
        s = '0;
        for (int j = 0; j < 8; j++) s = s + pos[j*16 +: 16];
        return s;
    endfunction

    function automatic logic [15:0] risk_of(input logic [15:0] psr, input logic [127:0] pos);
        logic [15:0] s;
        s = sum_of(pos);
        return 16'(psr * s);
    endfunction

    function automatic int pick_idx(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Engine model: result is valid only LAT cycles after the start edge, garbage otherwise.
    logic [15:0] eng_d [LAT] = '{default: 16'h0};
    logic        eng_v [LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            eng_d[k] <= eng_d[k-1];
            eng_v[k] <= eng_v[k-1];
        end
        eng_v[0] <= bus.eng_start;
        eng_d[0] <= risk_of(bus.eng_psr, bus.eng_pos);
    end

    assign bus.eng_risk = eng_v[LAT-1] ? eng_d[LAT-1] : 16'hBAD0;

    // Cycle model and scoreboard, sampled mid-cycle.
    int   cyc       = 0;
    int   m_start   = -1;
    int   m_resv    = -1;
    int   ptr       = 0;
    bit   m_idle    = 1'b1;
    int   n_starts  = 0;
    int   n_results = 0;
    exp_t sb[$];
    int   grant_log[$];

    always @(negedge clk) begin
        bit       was_idle;
        bit       exp_rv;
        int       gi;
        logic [3:0] exp_ready;
        exp_t     e;
        if (!reset) begin
            chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
            m_idle  = 1'b1;
            ptr     = 0;
            m_start = -1;
            m_resv  = -1;
            sb.delete();
        end else begin
            was_idle  = m_idle;
            gi        = was_idle ? pick_idx(bus.req_valid, ptr) : -1;
            exp_ready = (gi >= 0) ? 4'(1 << gi) : 4'h0;
            chk("req_ready", 128'(bus.req_ready), 128'(exp_ready));
            chk("eng_start", 128'(bus.eng_start), 128'(cyc == m_start));
            if (bus.eng_start) n_starts++;
            if ((bus.req_valid & bus.req_ready) != 4'h0) begin
                for (int i = 3; i >= 0; i--) if (bus.req_ready[i]) gi = i;
                grant_log.push_back(gi);
                gi = pick_idx(bus.req_valid, ptr);
            end
            if (cyc == m_start && sb.size() > 0) begin
                chk("eng_psr", 128'(bus.eng_psr), 128'(sb[0].psr));
                chk("eng_pos", bus.eng_pos, sb[0].pos);
            end
            exp_rv = (m_resv >= 0) && (cyc >= m_resv);
            chk("res_valid", 128'(bus.res_valid), 128'(exp_rv));
            if (exp_rv && bus.res_valid && sb.size() > 0) begin
                chk("res_id", 128'(bus.res_id), 128'(sb[0].id));
                chk("res_risk", 128'(bus.res_risk), 128'(sb[0].risk));
                if (bus.res_ready) begin
                    void'(sb.pop_front());
                    m_resv = -1;
                    m_idle = 1'b1;
                    n_results++;
                end
            end
            if (was_idle && gi >= 0) begin
                e.id   = gi;
                e.psr  = psr_a[gi];
                e.pos  = pos_a[gi];
                e.risk = risk_of(psr_a[gi], pos_a[gi]);
                m_idle = 1'b0;
                ptr    = (gi + 1) % 4;
                m_start = cyc + 1;
                m_resv  = cyc + 2 + LAT;
`ifdef SPAN_SCHED_ZERO_BYPASS_EN
                if (sum_of(pos_a[gi]) == 16'h0) begin
                    e.risk  = 16'h0;
                    m_start = -1;
                    m_resv  = cyc + 1;
                end
`endif
                sb.push_back(e);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int t = 0; t < 80 && idx < 0; t++) begin
            @(negedge clk);
            if (reset && (bus.req_valid & bus.req_ready) != 4'h0) begin
                for (int i = 3; i >= 0; i--) if (bus.req_ready[i]) idx = i;
            end
        end
        chk("grant_timeout", 128'(idx >= 0), 128'(1));
        tick();
    endtask

    task automatic wait_result(output logic [15:0] risk, output int id);
        bit got;
        got  = 1'b0;
        risk = '0;
        id   = -1;
        for (int t = 0; t < 80 && !got; t++) begin
            @(negedge clk);
            if (bus.res_valid && bus.res_ready) begin
                got  = 1'b1;
                risk = bus.res_risk;
                id   = int'(bus.res_id);
            end
        end
        chk("result_timeout", 128'(got), 128'(1));
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'(0));
        chk({tag, "_eng_start"}, 128'(bus.eng_start), 128'(0));
        chk({tag, "_eng_psr"}, 128'(bus.eng_psr), 128'(0));
        chk({tag, "_eng_pos"}, bus.eng_pos, 128'(0));
        chk({tag, "_res_valid"}, 128'(bus.res_valid), 128'(0));
        chk({tag, "_res_id"}, 128'(bus.res_id), 128'(0));
        chk({tag, "_res_risk"}, 128'(bus.res_risk), 128'(0));
    endtask

    initial begin
        int          g;
        int          id;
        int          base;
        int          mark;
        bit          seen;
        logic [15:0] r;
        int          fair_exp [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NREQ; i++) begin
            psr_a[i] = '0;
            pos_a[i] = '0;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        tick();

        // Fairness: everyone valid continuously from rr_ptr 0.
        for (int i = 0; i < 4; i++) begin
            psr_a[i] = 16'(10 * (i + 1));
            for (int j = 0; j < 8; j++) pos_a[i][j*16 +: 16] = 16'(i + j) - 16'd3;
        end
        base = grant_log.size();
        bus.req_valid = 4'hF;
        repeat (5) wait_grant(g);
        bus.req_valid = 4'h0;
        wait_result(r, id);
        chk("fair_last_id", 128'(id), 128'(0));
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", 128'(grant_log[base + k]), 128'(fair_exp[k]));
        end

        // Single request: psr 100, all positions 1.
        psr_a[0] = 16'd100;
        pos_a[0] = {8{16'd1}};
        bus.req_valid = 4'b0001;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("single_grant", 128'(g), 128'(0));
        wait_result(r, id);
        chk("single_risk", 128'(r), 128'(800));
        chk("single_id", 128'(id), 128'(0));

        // Backpressure with other requesters waiting.
        psr_a[3] = 16'd7;
        pos_a[3] = {8{16'd2}};
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1000;
        wait_grant(g);
        chk("bp_grant", 128'(g), 128'(3));
        bus.req_valid = 4'b0101;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.res_valid;
        end
        chk("bp_valid_seen", 128'(seen), 128'(1));
        repeat (10) tick();
        @(negedge clk);
        chk("bp_risk_held", 128'(bus.res_risk), 128'(112));
        chk("bp_id_held", 128'(bus.res_id), 128'(3));
        tick();
        bus.res_ready = 1'b1;
        wait_result(r, id);
        chk("bp_done_id", 128'(id), 128'(3));
        wait_grant(g);
        chk("bp_next_grant", 128'(g), 128'(0));
        bus.req_valid = 4'b0100;
        wait_grant(g);
        chk("bp_then_grant", 128'(g), 128'(2));
        bus.req_valid = 4'b0000;
        wait_result(r, id);

        // Wrap: rr_ptr is 3, only requester 1 valid.
        bus.req_valid = 4'b0010;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("wrap_grant", 128'(g), 128'(1));
        wait_result(r, id);
        bus.req_valid = 4'b1010;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("wrap_ptr2_grant", 128'(g), 128'(3));
        wait_result(r, id);

        // Reset during WAIT: the in-flight job is dropped and rr_ptr returns to 0.
        bus.req_valid = 4'b0100;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("rst_mid_grant", 128'(g), 128'(2));
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        mark = n_results;
        repeat (8) tick();
        chk("rst_no_result", 128'(n_results), 128'(mark));
        bus.req_valid = 4'b1001;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("rst_ptr_grant", 128'(g), 128'(0));
        wait_result(r, id);
        chk("rst_after_id", 128'(id), 128'(0));

        // Zero net position: pos = {5, -5, 0, ...}.
        psr_a[1] = 16'd50;
        pos_a[1] = '0;
        pos_a[1][15:0]  = 16'd5;
        pos_a[1][31:16] = 16'hFFFB;
        mark = n_starts;
        bus.req_valid = 4'b0010;
        wait_grant(g);
        bus.req_valid = 4'b0000;
        chk("zb_grant", 128'(g), 128'(1));
        wait_result(r, id);
        chk("zb_risk", 128'(r), 128'(0));
        chk("zb_id", 128'(id), 128'(1));
`ifdef SPAN_SCHED_ZERO_BYPASS_EN
        chk("zb_starts", 128'(n_starts - mark), 128'(0));
        chk("zb_eng_psr", 128'(bus.eng_psr), 128'(100));
`else
        chk("zb_starts", 128'(n_starts - mark), 128'(1));
        chk("zb_eng_psr", 128'(bus.eng_psr), 128'(50));
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
